multicycle_controller: RTL and testbench

// - Sequencing FSM for the RV32I data_path: fetches each instruction over a shared req/ready memory port and latches it in an internal IR.
// - Drives the datapath controls (alusrc, regwrite, pcsrc, immsrc, resultsrc, alucontrol) one phase at a time.
// - Gates PC and register-file updates so one instruction retires per FSM pass.
// - Sits between the unified memory port and data_path.

---
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle sequencing FSM for the RV32I data_path.
// Fetches over a shared req/ready port into an internal IR, then drives one
// phase of datapath controls per state. One instruction retires per pass.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode -> fault + HALT;
// when undefined an unknown opcode retires as a NOP).
module multicycle_controller #(
   parameter int unsigned MEM_WAIT_MAX = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        zero,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_isfetch,
   output logic [31:0] instr,
   output logic        pc_we,
   output logic        alusrc,
   output logic        regwrite,
   output logic [1:0]  pcsrc,
   output logic [1:0]  immsrc,
   output logic [1:0]  resultsrc,
   output logic [2:0]  alucontrol,
   output logic        fault
);

   localparam logic [31:0] InstrNop = 32'h0000_0013;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemRd, StMemWr, StAluWb, StBranch, StJump, StNop, StHalt
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        ir_q;
   logic               ir_load;
   logic               fault_q, fault_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               waiting, timeout;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;

   assign opcode   = ir_q[6:0];
   assign funct3   = ir_q[14:12];
   assign funct7b5 = ir_q[30];
   assign instr    = ir_q;
   assign fault    = fault_q;

   // A request is outstanding and memory has not answered this cycle.
   assign waiting = mem_req && !mem_ready;
   assign timeout = (MEM_WAIT_MAX != 0) && waiting && (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

   // State, IR, sticky fault and wait-counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         ir_q    <= InstrNop;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (ir_load) ir_q <= mem_rdata;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, IR load, fault and wait-counter logic.
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      ir_load = 1'b0;
      // Counter is zero whenever not waiting, so every req state is entered with a clear count.
      cnt_d   = '0;
      if (waiting && (MEM_WAIT_MAX != 0)) cnt_d = cnt_q + CNT_W'(1);

      unique case (state_q)
         StFetch: begin
            if (mem_ready) begin
               ir_load = 1'b1;
               state_d = StDecode;
            end else if (timeout) begin
               fault_d = 1'b1;
               state_d = StHalt;
            end
         end
         StDecode: begin
            unique case (opcode)
               OpLoad:           state_d = StMemRd;
               OpStore:          state_d = StMemWr;
               OpRtype, OpItype: state_d = StAluWb;
               OpBranch:         state_d = StBranch;
               OpJal, OpJalr:    state_d = StJump;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  fault_d = 1'b1;
                  state_d = StHalt;
`else
                  state_d = StNop;
`endif
               end
            endcase
         end
         StMemRd, StMemWr: begin
            if (mem_ready) begin
               state_d = StFetch;
            end else if (timeout) begin
               fault_d = 1'b1;
               state_d = StHalt;
            end
         end
         StAluWb, StBranch, StJump, StNop: state_d = StFetch;
         StHalt:                           state_d = StHalt;
         default:                          state_d = StFetch;
      endcase
   end

   // Control outputs decoded from state and IR; writeback/PC strobes of memory
   // states fire only in the cycle the transfer completes.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_isfetch = 1'b0;
      pc_we       = 1'b0;
      alusrc      = 1'b0;
      regwrite    = 1'b0;
      pcsrc       = 2'b00;
      immsrc      = 2'b00;
      resultsrc   = 2'b00;
      alucontrol  = AluAdd;

      unique case (state_q)
         StFetch: begin
            mem_req     = 1'b1;
            mem_isfetch = 1'b1;
         end
         StMemRd: begin
            mem_req  = 1'b1;
            alusrc   = 1'b1;
            immsrc   = 2'b00;
            if (mem_ready) begin
               regwrite  = 1'b1;
               resultsrc = 2'b01;
               pc_we     = 1'b1;
            end
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            alusrc  = 1'b1;
            immsrc  = 2'b01;
            if (mem_ready) pc_we = 1'b1;
         end
         StAluWb: begin
            regwrite = 1'b1;
            pc_we    = 1'b1;
            alusrc   = (opcode == OpItype);
            unique case (funct3)
               3'b000:  alucontrol = (opcode == OpRtype && funct7b5) ? AluSub : AluAdd;
               3'b010:  alucontrol = AluSlt;
               3'b110:  alucontrol = AluOr;
               3'b111:  alucontrol = AluAnd;
               default: alucontrol = AluAdd;
            endcase
         end
         StBranch: begin
            alucontrol = AluSub;
            immsrc     = 2'b10;
            pc_we      = 1'b1;
            pcsrc      = zero ? 2'b01 : 2'b00;
         end
         StJump: begin
            regwrite  = 1'b1;
            resultsrc = 2'b10;
            pc_we     = 1'b1;
            if (opcode == OpJal) begin
               immsrc = 2'b11;
               pcsrc  = 2'b01;
            end else begin
               alusrc = 1'b1;
               pcsrc  = 2'b10;
            end
         end
         StNop: pc_we = 1'b1;
         StDecode, StHalt: ;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of per-cycle vectors
// plus hand-written timeout and reset-during-load sequences.
module tb_multicycle_controller;

   logic        clk, rst, mem_ready, zero;
   logic [31:0] mem_rdata, instr;
   logic        mem_req, mem_we, mem_isfetch, pc_we, alusrc, regwrite, fault;
   logic [1:0]  pcsrc, immsrc, resultsrc;
   logic [2:0]  alucontrol;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_controller #(.MEM_WAIT_MAX(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .zero(zero),
      .mem_req(mem_req), .mem_we(mem_we), .mem_isfetch(mem_isfetch), .instr(instr),
      .pc_we(pc_we), .alusrc(alusrc), .regwrite(regwrite), .pcsrc(pcsrc), .immsrc(immsrc),
      .resultsrc(resultsrc), .alucontrol(alucontrol), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        chk;
      logic        rst;
      logic        rdy;
      logic        z;
      logic [31:0] rdata;
      logic [15:0] exp;
      logic [31:0] ir;
      logic [95:0] nm;
   } rec_t;

   rec_t        tbl[$];
   logic [31:0] m_ir;

   // {req, we, isfetch, pc_we, alusrc, regwrite, pcsrc, immsrc, resultsrc, alucontrol, fault}
   function automatic logic [15:0] ctl(input logic req, input logic we, input logic isf,
                                       input logic pcwe, input logic asrc, input logic rw,
                                       input logic [1:0] pcs, input logic [1:0] imm,
                                       input logic [1:0] res, input logic [2:0] alu,
                                       input logic f);
      return {req, we, isf, pcwe, asrc, rw, pcs, imm, res, alu, f};
   endfunction

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [15:0] c_fetch, c_dec, c_addi, c_lw, c_lw_wait, c_sw, c_beq_t, c_beq_n;
   logic [15:0] c_jal, c_jalr, c_sub, c_or, c_nop, c_halt_f;

   // Drive one cycle of inputs at the falling edge and check outputs 1ns later.
   task automatic cyc(input logic chk, input logic r, input logic rdy, input logic [31:0] rd,
                      input logic z, input logic [15:0] exp, input logic [31:0] ir,
                      input logic [95:0] nm);
      logic [15:0] got;
      @(negedge clk);
      rst = r; mem_ready = rdy; mem_rdata = rd; zero = z;
      #1;
      got = {mem_req, mem_we, mem_isfetch, pc_we, alusrc, regwrite, pcsrc, immsrc,
             resultsrc, alucontrol, fault};
      if (chk) begin
         n_cmp++;
         if (got !== exp || instr !== ir) begin
            n_err++;
            $display("FAIL %0s @%0t: ctl=%h instr=%h, required ctl=%h instr=%h",
                     nm, $time, got, instr, exp, ir);
         end
      end
   endtask

   task automatic add(input logic chk, input logic r, input logic rdy, input logic [31:0] rd,
                      input logic z, input logic [15:0] exp, input logic [31:0] ir,
                      input logic [95:0] nm);
      rec_t e;
      e.chk = chk; e.rst = r; e.rdy = rdy; e.z = z; e.rdata = rd;
      e.exp = exp; e.ir = ir; e.nm = nm;
      tbl.push_back(e);
   endtask

   // Fetch with a given number of wait cycles, then the DECODE cycle.
   task automatic add_fetch(input logic [31:0] ins, input int waits);
      for (int i = 0; i < waits; i++) add(1, 0, 0, 32'hDEAD_BEEF, 0, c_fetch, m_ir, "fetch_wait");
      add(1, 0, 1, ins, 0, c_fetch, m_ir, "fetch_done");
      m_ir = ins;
      add(1, 0, 0, 32'h0, 0, c_dec, m_ir, "decode");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      c_fetch   = ctl(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      c_dec     = 16'h0000;
      c_addi    = ctl(0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      c_lw      = ctl(1, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'b01, 3'b000, 0);
      c_lw_wait = ctl(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      c_sw      = ctl(1, 1, 0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 3'b000, 0);
      c_beq_t   = ctl(0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 3'b001, 0);
      c_beq_n   = ctl(0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
      c_jal     = ctl(0, 0, 0, 1, 0, 1, 2'b01, 2'b11, 2'b10, 3'b000, 0);
      c_jalr    = ctl(0, 0, 0, 1, 1, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0);
      c_sub     = ctl(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b001, 0);
      c_or      = ctl(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b011, 0);
      c_nop     = ctl(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      c_halt_f  = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);

      rst = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0; zero = 1'b0;

      // ---------------- vector table ----------------
      m_ir = NOP;
      add(0, 1, 0, 32'h0, 0, c_fetch, m_ir, "rst");
      add(0, 1, 0, 32'h0, 0, c_fetch, m_ir, "rst");
      add_fetch(32'h0050_0093, 3);                                // addi x1,x0,5
      add(1, 0, 0, 32'h0, 0, c_addi, m_ir, "aluwb_addi");
      add_fetch(32'h0000_A103, 0);                                // lw
      add(1, 0, 1, 32'h1234_5678, 0, c_lw, m_ir, "memrd_lw");
      add_fetch(32'h0020_A223, 0);                                // sw
      add(1, 0, 1, 32'h0, 0, c_sw, m_ir, "memwr_sw");
      add_fetch(32'h0020_8463, 0);                                // beq, taken
      add(1, 0, 0, 32'h0, 1, c_beq_t, m_ir, "beq_taken");
      add_fetch(32'h0020_8463, 0);                                // beq, not taken
      add(1, 0, 0, 32'h0, 0, c_beq_n, m_ir, "beq_not");
      add_fetch(32'h0080_00EF, 0);                                // jal
      add(1, 0, 0, 32'h0, 0, c_jal, m_ir, "jal");
      add_fetch(32'h0000_80E7, 0);                                // jalr
      add(1, 0, 0, 32'h0, 0, c_jalr, m_ir, "jalr");
      add_fetch(32'h4020_81B3, 0);                                // sub x3,x1,x2
      add(1, 0, 0, 32'h0, 0, c_sub, m_ir, "aluwb_sub");
      add_fetch(32'h0020_E1B3, 15);                               // or, one short of timeout
      add(1, 0, 0, 32'h0, 0, c_or, m_ir, "aluwb_or");
      add_fetch(32'h4000_0093, 0);                                // addi imm bit30: still add
      add(1, 0, 0, 32'h0, 0, c_addi, m_ir, "addi_b30");
      add_fetch(32'h0000_007F, 0);                                // opcode 1111111
`ifdef ILLEGAL_TRAP_EN
      add(1, 0, 0, 32'h0, 0, c_halt_f, m_ir, "illegal");
      add(1, 1, 0, 32'h0, 0, c_halt_f, m_ir, "illegal_rst");
`else
      add(1, 0, 0, 32'h0, 0, c_nop, m_ir, "illegal");
      add(1, 1, 0, 32'h0, 0, c_fetch, m_ir, "illegal_rst");
`endif
      m_ir = NOP;
      add(1, 0, 0, 32'h0, 0, c_fetch, m_ir, "post_rst");

      foreach (tbl[i]) cyc(tbl[i].chk, tbl[i].rst, tbl[i].rdy, tbl[i].rdata, tbl[i].z,
                           tbl[i].exp, tbl[i].ir, tbl[i].nm);

      // ---------------- timeout: 16 unanswered fetch cycles ----------------
      // FETCH entered on the last table vector (already one waiting cycle); 15 more here.
      for (int i = 0; i < 15; i++) cyc(1, 0, 0, 32'h0, 0, c_fetch, NOP, "to_wait");
      cyc(1, 0, 1, 32'hFFFF_FFFF, 0, c_halt_f, NOP, "halt");      // ready ignored in HALT
      cyc(1, 0, 1, 32'hFFFF_FFFF, 0, c_halt_f, NOP, "halt_hold");
      cyc(1, 1, 0, 32'h0, 0, c_halt_f, NOP, "halt_rst");
      cyc(1, 0, 1, 32'h0000_A103, 0, c_fetch, NOP, "post_rst");

      // ---------------- reset while a load waits for memory ----------------
      cyc(1, 0, 0, 32'h0, 0, c_dec, 32'h0000_A103, "decode");
      cyc(1, 0, 0, 32'h0, 0, c_lw_wait, 32'h0000_A103, "rd_wait");
      cyc(1, 1, 0, 32'h0, 0, c_lw_wait, 32'h0000_A103, "rd_rst");
      cyc(1, 0, 0, 32'h0, 0, c_fetch, NOP, "rd_post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
